// File: rtl/input_cond_pkg.sv
// Shared helpers for the input conditioner: counter sizing and parameter legality.
package input_cond_pkg;

  function automatic int cnt_width(int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(int width, int stages, int debounce_cycles);
    return (width >= 1) && (stages >= 2) && (debounce_cycles >= 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle: raw inputs in, conditioned levels and event pulses out.
interface input_conditioner_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_rise;

    modport master (output in, input level, rise, fall, any_rise);
    modport slave  (input in, output level, rise, fall, any_rise);
endinterface

// File: rtl/debounce_channel.sv
// One channel: synchronizer chain, debounce counter, accepted level and edge pulses.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_next
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] sync;
    logic              s;
    logic [CW-1:0]     cnt, cnt_next;
    logic              level_next, fall_next;

    assign s = sync[STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        level_next = level;
        cnt_next   = '0;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s != level) begin
            if (cnt == CNT_LAST) begin
                level_next = s;
                rise_next  = s;
                fall_next  = ~s;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= RESET_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], in};
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input front end: WIDTH independent debounce channels plus a registered any_rise.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input logic                clk,
    input logic                reset,
    input_conditioner_if.slave bus
);

    if (!params_legal(WIDTH, STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
        $error("input_conditioner: illegal parameters (WIDTH>=1, STAGES>=2, DEBOUNCE_CYCLES>=1)");
    end

    logic [WIDTH-1:0] level, rise, fall, rise_next;
    logic             any_rise;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[i])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in        (bus.in[i]),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .rise_next (rise_next[i])
        );
    end

    // Built from the channels' next-state rise so it lands on the same edge as rise.
    always_ff @(posedge clk) begin
        if (reset) any_rise <= 1'b0;
        else       any_rise <= |rise_next;
    end

    assign bus.level    = level;
    assign bus.rise     = rise;
    assign bus.fall     = fall;
    assign bus.any_rise = any_rise;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: two configurations driven with the same stimulus, checked against a run-length model.
module tb_input_conditioner;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any_rise;
    } out_t;
    typedef out_t [1:0] pair_t;

    localparam int         N_DUT = 2;
    localparam int         STG [N_DUT] = '{2, 3};
    localparam int         DEB [N_DUT] = '{4, 1};
    localparam logic [3:0] RV  [N_DUT] = '{4'b0000, 4'b1111};

    logic       clk = 1'b0;
    logic       reset_v = 1'b1;
    logic [3:0] in_v = 4'b0000;

    always #5 clk = ~clk;

    input_conditioner_if #(.WIDTH(4)) bus0 ();
    input_conditioner_if #(.WIDTH(4)) bus1 ();
    assign bus0.in = in_v;
    assign bus1.in = in_v;

    input_conditioner #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b0000))
        u_dut0 (.clk(clk), .reset(reset_v), .bus(bus0));
    input_conditioner #(.WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'b1111))
        u_dut1 (.clk(clk), .reset(reset_v), .bus(bus1));

    // Reference model: raw samples since reset, accepted level, and length of the current mismatch run.
    logic [3:0] hist [$];
    logic [3:0] m_level [N_DUT];
    int         run [N_DUT][4];
    pair_t      sb [$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // The synced value seen at an edge is the raw sample taken STAGES edges earlier (0 if none since reset).
    task automatic model_edge(logic rst, logic [3:0] smp);
        pair_t e;
        if (rst) begin
            hist.delete();
            for (int d = 0; d < N_DUT; d++) begin
                m_level[d] = RV[d];
                for (int c = 0; c < 4; c++) run[d][c] = 0;
                e[d] = '{level: RV[d], rise: 4'b0, fall: 4'b0, any_rise: 1'b0};
            end
        end else begin
            hist.push_front(smp);
            if (hist.size() > 8) void'(hist.pop_back());
            for (int d = 0; d < N_DUT; d++) begin
                logic [3:0] r, f;
                r = '0;
                f = '0;
                for (int c = 0; c < 4; c++) begin
                    logic [3:0] old;
                    logic       s;
                    s = 1'b0;
                    if (hist.size() > STG[d]) begin
                        old = hist[STG[d]];
                        s   = old[c];
                    end
                    if (s != m_level[d][c]) begin
                        run[d][c]++;
                        if (run[d][c] == DEB[d]) begin
                            m_level[d][c] = s;
                            run[d][c]     = 0;
                            r[c]          = s;
                            f[c]          = ~s;
                        end
                    end else begin
                        run[d][c] = 0;
                    end
                end
                e[d] = '{level: m_level[d], rise: r, fall: f, any_rise: |r};
            end
        end
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(reset_v, in_v);
        #1;
    endtask

    task automatic hold(logic [3:0] v, int n);
        in_v = v;
        repeat (n) tick();
    endtask

    // Monitor: outputs are registered, so every negedge presents one result per queued edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            pair_t e;
            e = sb.pop_front();
            check("d0.level",    bus0.level,              e[0].level);
            check("d0.rise",     bus0.rise,               e[0].rise);
            check("d0.fall",     bus0.fall,               e[0].fall);
            check("d0.any_rise", {3'b0, bus0.any_rise},   {3'b0, e[0].any_rise});
            check("d1.level",    bus1.level,              e[1].level);
            check("d1.rise",     bus1.rise,               e[1].rise);
            check("d1.fall",     bus1.fall,               e[1].fall);
            check("d1.any_rise", {3'b0, bus1.any_rise},   {3'b0, e[1].any_rise});
        end
    end

    initial begin
        // Reset with quiet inputs, then stay quiet.
        reset_v = 1'b1;
        hold(4'b0000, 3);
        reset_v = 1'b0;
        hold(4'b0000, 10);

        // Channel 0 press and release.
        hold(4'b0001, 12);
        hold(4'b0000, 12);

        // Channel 1 short glitches, then one accepted pulse.
        repeat (5) begin
            hold(4'b0010, 3);
            hold(4'b0000, 4);
        end
        hold(4'b0010, 4);
        hold(4'b0000, 12);

        // Channels 0 and 2 together.
        hold(4'b0101, 10);
        hold(4'b0000, 10);

        // Channel 3 held; reset lands while its counter is at 2.
        hold(4'b1000, 4);
        reset_v = 1'b1;
        hold(4'b1000, 2);
        reset_v = 1'b0;
        hold(4'b1000, 12);
        hold(4'b0000, 10);

        // Random holds with occasional resets.
        for (int i = 0; i < 300; i++) begin
            reset_v = ($urandom_range(0, 49) == 0);
            hold(4'($urandom), $urandom_range(1, 8));
        end
        reset_v = 1'b0;
        hold(4'b0000, 12);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel input front end for the game's asynchronous push-button and switch inputs. It replaces per-signal two-flop synchronizers with a single block that has a configurable synchronizer depth, a per-channel debounce filter, and registered one-cycle rise/fall event pulses. It sits between the FPGA input pins and the game-control FSMs, so downstream logic sees only clean, clock-aligned levels and single-cycle press/release events.

## Interface
- WIDTH, 4: number of independent input channels (>=1)
- STAGES, 2: synchronizer flops per channel (>=2)
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles a new value must hold before `level` accepts it (>=1; 1 means no filtering)
- RESET_VAL, '0: WIDTH-bit reset value of `level`, one bit per channel

- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- in  input  WIDTH  asynchronous raw inputs
- level  output  WIDTH  debounced, synchronized level per channel
- rise  output  WIDTH  one-cycle pulse when `level` goes 0->1
- fall  output  WIDTH  one-cycle pulse when `level` goes 1->0
- any_rise  output  1  OR-reduction of `rise`, registered with it

## Operation
- Each channel runs independently through a STAGES-deep flop chain. The last flop is the synced value `s`.
- Each channel has a counter `cnt`, width max(1, $clog2(DEBOUNCE_CYCLES)). On every clock edge:
  - if `s == level`: cnt <= 0; rise and fall deassert.
  - if `s != level` and `cnt == DEBOUNCE_CYCLES-1`: level <= s; cnt <= 0; rise or fall asserts according to the new value.
  - otherwise: cnt <= cnt + 1; rise and fall deassert.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES synchronized cycles resets `cnt` when it ends, and `level` does not change.
- rise and fall are never asserted together on one channel. Each pulse lasts exactly one cycle.
- Channels do not interact. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Reset applies to every channel:
  - all sync flops <= 0
  - level <= RESET_VAL
  - cnt <= 0
  - rise, fall, any_rise <= 0
- Reset in mid-count discards any pending change.
- After reset, if a held input differs from RESET_VAL, the normal filter runs and the resulting edge pulse is reported.

## Timing
- All outputs are registered. There is no combinational path from `in` to any output.
- Latency: let edge k be the first edge that samples a new value of `in`, with `in` held stable afterwards. Then `level`, `rise`/`fall` and `any_rise` update at edge k + STAGES + DEBOUNCE_CYCLES - 1.
  - Defaults (2, 4): edge k+5.
  - STAGES=2, DEBOUNCE_CYCLES=1: edge k+2.
- Minimum accepted pulse width on `in` is DEBOUNCE_CYCLES clock cycles.
- Minimum spacing between opposite-direction events on one channel is DEBOUNCE_CYCLES cycles.
- The counter never wraps: it saturates by clearing at DEBOUNCE_CYCLES-1.

## Structure
- Package `input_cond_pkg` holds:
  - function `cnt_width(int n)`, returning max(1, $clog2(n))
  - the parameter legality checks (STAGES>=2, DEBOUNCE_CYCLES>=1, WIDTH>=1), written as elaboration-time assertions
- Sub-module `debounce_channel` contains:
  - one channel's sync chain, counter, level, rise and fall
  - parameters STAGES, DEBOUNCE_CYCLES, RESET_BIT
- The top level instantiates WIDTH copies of `debounce_channel` in a generate loop and registers `any_rise` itself.

## Test plan
- Reset with in=4'b0000 and RESET_VAL=0 (defaults) -> level=0, rise=fall=any_rise=0 on the cycle after reset deasserts; outputs stay quiet for 10 cycles.
- Channel 0 driven 0->1 before edge k and held -> level[0]=1 and rise[0]=1, any_rise=1 after edge k+5; rise[0]=0 from edge k+6; 1->0 later -> fall[0] pulses once, 5 edges after sampling.
- Channel 1 given 3-cycle high glitches (DEBOUNCE_CYCLES=4) repeated 5 times -> level[1] stays 0 and no pulses; a 4-cycle pulse -> exactly one rise[1], then one fall[1].
- Channels 0 and 2 both rise at the same edge -> rise=4'b0101 for one cycle, any_rise=1.
- in[3]=1 held; reset asserted at cnt=2 and held for 2 cycles -> no event before reset; after reset deasserts, level[3] rises exactly STAGES+DEBOUNCE_CYCLES-1 edges after the first post-reset sampling edge.
- Reruns with STAGES=3, DEBOUNCE_CYCLES=1, RESET_VAL=4'b1111 -> latency 3 edges; after reset with in=0, fall=4'b1111 for one cycle.
